// File: rtl/data_ram_pipelined_pkg.sv
// Shared types for the pipelined data RAM and its lane-alignment helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_ram_pipelined_pkg;

    // RISC-V load/store funct3 encoding of the access width and signedness
    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_size_t;

    // Reserved cause codes for when the fault flag grows into a cause field
    localparam logic [1:0] MEM_FAULT_NONE     = 2'd0;
    localparam logic [1:0] MEM_FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] MEM_FAULT_RANGE    = 2'd2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_t;

    // One slot of the response pipeline
    typedef struct packed {
        logic        vld;
        logic [31:0] rdata;
        logic        fault;
    } resp_stage_t;

endpackage

// File: rtl/data_ram_pipelined_if.sv
// Request/response bundle between the CPU memory stage and the data RAM.
// Latency: n/a (wiring only).
// Backpressure: requests gated by req_ready; responses are never stalled.
interface data_ram_pipelined_if;
    import data_ram_pipelined_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_size_t   req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/data_ram_pipelined_mem_align.sv
// Sub-word lane steering: byte enables, store lane replication, load extract/extend.
// Latency: combinational.
// Backpressure: none.
module mem_align
    import data_ram_pipelined_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);
    logic [15:0] lane;

    // Decode width/signedness; undefined size encodings are reported as faults
    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = wdata;
        load_data  = 32'h0;
        misaligned = 1'b0;
        lane       = 16'(rword >> {addr_lo, 3'b000});
        case (size)
            MEM_B, MEM_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = (size == MEM_B) ? {{24{lane[7]}}, lane[7:0]}
                                             : {24'h0, lane[7:0]};
            end
            MEM_H, MEM_HU: begin
                misaligned = addr_lo[0];
                byte_en    = 4'b0011 << addr_lo;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = (size == MEM_H) ? {{16{lane[15]}}, lane}
                                             : {16'h0, lane};
            end
            MEM_W: begin
                misaligned = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
                load_data  = rword;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_ram_pipelined.sv
// Single-port 32-bit data RAM with RISC-V sub-word access and a fixed-latency response pipe.
// Latency: READ_LATENCY cycles from acceptance to resp_valid; one request per cycle.
// Backpressure: req_ready low only during post-reset zero-fill; responses cannot stall.
module data_ram_pipelined
    import data_ram_pipelined_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 128,
    parameter int          READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input logic                 clk,
    input logic                 rst_n,
    data_ram_pipelined_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    ram_state_t    state_q, state_d;
    logic [AW-1:0] clr_cnt_q;
    logic          clr_we;
    logic          req_ready;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] widx;
    logic          out_of_range, misaligned, fault, accept;
    logic [3:0]    byte_en;
    logic [31:0]   lane_wdata, rword, load_data;
    resp_stage_t   pipe_in;
    resp_stage_t   pipe_q [READ_LATENCY];

    assign offset       = bus.req_addr - BASE_ADDR;
    assign widx         = offset[AW+1:2];
    assign out_of_range = (offset >= SPAN);
    assign fault        = out_of_range | misaligned;
    assign accept       = bus.req_valid & req_ready;
    assign rword        = mem[widx];
    assign bus.req_ready = req_ready;

    mem_align u_align (
        .size       (bus.req_size),
        .addr_lo    (bus.req_addr[1:0]),
        .wdata      (bus.req_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // State register and zero-fill counter; reset always restarts the fill at word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we) clr_cnt_q <= clr_cnt_q + AW'(1);
        end
    end

    // Next state: INIT clears one word per cycle, RUN accepts a request every cycle
    always_comb begin
        state_d   = state_q;
        clr_we    = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    clr_we = 1'b1;
                    if (clr_cnt_q == AW'(DEPTH_WORDS - 1)) state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  req_ready = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    // Array write port: zero-fill during INIT, masked store in RUN (faulting stores dropped)
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (accept && bus.req_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[widx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    // Stores and faulting accesses respond with zero data
    assign pipe_in = '{vld:   accept,
                       rdata: (accept && !bus.req_we && !fault) ? load_data : 32'h0,
                       fault: accept & fault};

    // Response shift register; slot 0 holds the array read, the rest add latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus.resp_valid = pipe_q[READ_LATENCY-1].vld;
    assign bus.resp_rdata = pipe_q[READ_LATENCY-1].rdata;
    assign bus.resp_fault = pipe_q[READ_LATENCY-1].fault;

endmodule

// File: tb/tb_data_ram_pipelined.sv
// Directed plus randomized checks of data_ram_pipelined against a byte-array reference.
// Latency: expects each response exactly LAT cycles after acceptance.
// Backpressure: requests issued only once req_ready is seen high after INIT.
module tb_data_ram_pipelined;
    import data_ram_pipelined_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int SPAN  = 4 * DEPTH;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        f;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic [7:0] rb [SPAN];
    exp_t exp_q [$];

    data_ram_pipelined_if bus ();

    data_ram_pipelined #(
        .DEPTH_WORDS    (DEPTH),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1'b1),
        .BASE_ADDR      (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Behavioural memory: plain byte array, little-endian, bounds and alignment by arithmetic
    function automatic void model(input logic we, input mem_size_t sz, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic f);
        int n;
        logic [2:0]  s;
        logic [31:0] v;
        s  = sz;
        n  = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
        f  = (a >= 32'(SPAN)) || ((a & 32'(n - 1)) != 32'h0);
        rd = 32'h0;
        if (!f) begin
            if (we) begin
                for (int i = 0; i < n; i++) rb[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(rb[int'(a) + i]) << (8 * i));
                if (!s[2]) begin
                    if (n == 1) v = {{24{v[7]}}, v[7:0]};
                    else if (n == 2) v = {{16{v[15]}}, v[15:0]};
                end
                rd = v;
            end
        end
    endfunction

    task automatic check_resp();
        logic ev;
        exp_t e;
        while (exp_q.size() != 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
        ev = 1'b0;
        if (exp_q.size() != 0) ev = (exp_q[0].due == cyc);
        chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
        if (ev) begin
            e = exp_q.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.d);
            chk("resp_fault", 32'(bus.resp_fault), 32'(e.f));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_resp();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // One request in the current cycle; lit selects literal expectations over the model
    task automatic req(input logic we, input mem_size_t sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit lit, input logic [31:0] lit_d,
                       input logic lit_f);
        exp_t e;
        logic [31:0] md;
        logic mf;
        model(we, sz, a, wd, md, mf);
        e.due = cyc + LAT;
        e.d   = lit ? lit_d : md;
        e.f   = lit ? lit_f : mf;
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        check_resp();
        @(posedge clk);
        #1;
        cyc++;
        bus.req_valid = 1'b0;
    endtask

    task automatic ld(input mem_size_t sz, input logic [31:0] a, input logic [31:0] d, input logic f);
        req(1'b0, sz, a, 32'h0, 1'b1, d, f);
    endtask

    task automatic st(input mem_size_t sz, input logic [31:0] a, input logic [31:0] wd);
        req(1'b1, sz, a, wd, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    // Counts cycles with req_ready low (up to limit), checking no response appears meanwhile
    task automatic count_init(output int n, input int limit);
        logic rdy;
        n = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            check_resp();
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) break;
            n++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < SPAN; i++) rb[i] = 8'h00;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        mem_size_t sz;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = MEM_W;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;

        // Reset values and zero-fill duration
        do_reset();
        count_init(n, 100);
        chk("init_cycles", 32'(n), 32'(DEPTH));
        model_clear();
        ld(MEM_W, 32'h08, 32'h0, 1'b0);
        idle(LAT);

        // Word store overlaid with a byte store, then signed/unsigned byte loads
        st(MEM_W, 32'h10, 32'h8899AABB);
        st(MEM_B, 32'h12, 32'h0000007F);
        ld(MEM_W,  32'h10, 32'h887FAABB, 1'b0);
        ld(MEM_B,  32'h13, 32'hFFFFFF88, 1'b0);
        ld(MEM_BU, 32'h13, 32'h00000088, 1'b0);

        // Halfword store/loads and a misaligned halfword load
        st(MEM_H, 32'h22, 32'h0000BEEF);
        ld(MEM_H,  32'h22, 32'hFFFFBEEF, 1'b0);
        ld(MEM_HU, 32'h22, 32'h0000BEEF, 1'b0);
        ld(MEM_H,  32'h21, 32'h0, 1'b1);
        ld(MEM_W,  32'h20, 32'hBEEF0000, 1'b0);

        // Faulting stores must not write anything
        req(1'b1, MEM_W, 32'(SPAN), 32'hDEADBEEF, 1'b1, 32'h0, 1'b1);
        ld(MEM_W, 32'h00, 32'h0, 1'b0);
        req(1'b1, MEM_W, 32'h11, 32'h12345678, 1'b1, 32'h0, 1'b1);
        req(1'b1, MEM_H, 32'h23, 32'h00005555, 1'b1, 32'h0, 1'b1);
        req(1'b1, MEM_B, 32'hF000_0000, 32'h000000AA, 1'b1, 32'h0, 1'b1);
        ld(MEM_W, 32'h10, 32'h887FAABB, 1'b0);
        ld(MEM_W, 32'h20, 32'hBEEF0000, 1'b0);
        ld(MEM_W, 32'(SPAN - 4), 32'h0, 1'b0);
        idle(LAT + 1);

        // Randomized traffic with occasional idle cycles
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
            end else begin
                case ($urandom_range(0, 4))
                    0:       sz = MEM_B;
                    1:       sz = MEM_H;
                    2:       sz = MEM_W;
                    3:       sz = MEM_BU;
                    default: sz = MEM_HU;
                endcase
                if ($urandom_range(0, 15) == 0) a = $urandom;
                else a = 32'($urandom_range(0, SPAN + 7));
                if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
                req(1'($urandom_range(0, 1)), sz, a, $urandom, 1'b0, 32'h0, 1'b0);
            end
        end
        idle(LAT + 1);

        // Reset with two loads in flight: responses vanish, full refill follows
        ld(MEM_W, 32'h10, 32'h0, 1'b0);
        ld(MEM_W, 32'h14, 32'h0, 1'b0);
        do_reset();
        count_init(n, 100);
        chk("init_after_flight", 32'(n), 32'(DEPTH));
        model_clear();

        // Dirty the array, then reset mid-fill at word 5 and again to completion
        st(MEM_W, 32'h00, 32'hCAFEF00D);
        st(MEM_W, 32'h3C, 32'h01020304);
        idle(LAT);
        do_reset();
        count_init(n, 5);
        chk("init_abort_point", 32'(n), 32'd5);
        do_reset();
        count_init(n, 100);
        chk("init_restart", 32'(n), 32'(DEPTH));
        model_clear();

        // Whole array must read back as zero after the refill
        for (int w = 0; w < DEPTH; w++) req(1'b0, MEM_W, 32'(4 * w), 32'h0, 1'b0, 32'h0, 1'b0);
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
